// File: rtl/bridge_mux.sv
// CPU-to-peripheral bridge: slot decode, request/ready FSM with timeout, interrupt mask/pend.
// Optional macro BRIDGE_INT_EDGE_EN: edge-latched, write-1-clear INT_PEND (default: level).
module bridge_mux #(
    parameter int          NDEV      = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          SLOT_BITS = 4,
    parameter int          TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PrReq,
    input  logic [29:0]            PrAddr,
    input  logic [3:0]             PrBE,
    input  logic                   PrWe,
    input  logic [31:0]            PrWD,
    output logic [31:0]            PrRD,
    output logic                   PrReady,
    output logic                   PrErr,
    output logic [7:2]             HWInt,
    output logic [NDEV-1:0]        DevSel,
    output logic                   DevWe,
    output logic [SLOT_BITS-3:0]   DevAddr,
    output logic [3:0]             DevBE,
    output logic [31:0]            DevWD,
    input  logic [NDEV*32-1:0]     DevRD,
    input  logic [NDEV-1:0]        DevAck,
    input  logic [NDEV-1:0]        DevInt
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [SLOT_BITS-3:0] W_MASK = (SLOT_BITS-2)'(0);
    localparam logic [SLOT_BITS-3:0] W_PEND = (SLOT_BITS-2)'(1);
    localparam logic [SLOT_BITS-3:0] W_ERR  = (SLOT_BITS-2)'(2);

    state_t              state;
    logic [7:0]          cnt;
    logic [2:0]          sel_idx;
    logic                lat_we;
    logic [31:0]         lat_addr;
    logic [NDEV-1:0]     int_mask;
    logic [NDEV-1:0]     int_pend;
    logic [31:0]         err_addr;

    logic [31:0]         byte_addr;
    logic [31:0]         off;
    logic [31:0]         slot;
    logic                below;
    logic                dev_hit;
    logic                reg_hit;
    logic [SLOT_BITS-3:0] woff;
    logic [31:0]         reg_rd;
    logic [31:0]         rd_sel;
    logic                ack_hit;
    logic [5:0]          hw_nxt;

    always_comb begin
        byte_addr = {PrAddr, 2'b00};
        below     = byte_addr < BASE_ADDR;
        off       = byte_addr - BASE_ADDR;
        slot      = off >> SLOT_BITS;
        dev_hit   = !below && (slot < 32'(NDEV));
        reg_hit   = !below && (slot == 32'(NDEV));
        woff      = off[SLOT_BITS-1:2];
    end

    always_comb begin
        reg_rd = '0;
        if (woff == W_MASK)
            reg_rd[NDEV-1:0] = int_mask;
        else if (woff == W_PEND)
            reg_rd[NDEV-1:0] = int_pend;
        else if (woff == W_ERR)
            reg_rd = err_addr;
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NDEV; i++)
            if (sel_idx == 3'(i))
                rd_sel = DevRD[i*32 +: 32];
    end

    assign ack_hit = |(DevAck & DevSel);

    always_comb begin
        hw_nxt = '0;
        hw_nxt[NDEV-1:0] = int_pend & int_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_idx  <= '0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            int_mask <= '1;
            err_addr <= '0;
            PrRD     <= '0;
            PrReady  <= 1'b0;
            PrErr    <= 1'b0;
            HWInt    <= '0;
            DevSel   <= '0;
            DevWe    <= 1'b0;
            DevAddr  <= '0;
            DevBE    <= '0;
            DevWD    <= '0;
        end else begin
            PrReady <= 1'b0;
            HWInt   <= hw_nxt;
            unique case (state)
                IDLE: begin
                    if (PrReq) begin
                        DevAddr  <= woff;
                        DevBE    <= PrBE;
                        DevWD    <= PrWD;
                        lat_we   <= PrWe;
                        lat_addr <= byte_addr;
                        PrErr    <= 1'b0;
                        if (dev_hit) begin
                            state   <= ACCESS;
                            cnt     <= '0;
                            sel_idx <= slot[2:0];
                            DevSel  <= NDEV'(1) << slot[2:0];
                            DevWe   <= PrWe;
                        end else if (reg_hit) begin
                            state   <= DONE;
                            PrReady <= 1'b1;
                            if (!PrWe)
                                PrRD <= reg_rd;
                            else if (PrBE[0] && woff == W_MASK)
                                int_mask <= PrWD[NDEV-1:0];
                        end else begin
                            state    <= DONE;
                            PrReady  <= 1'b1;
                            PrErr    <= 1'b1;
                            PrRD     <= '1;
                            err_addr <= byte_addr;
                        end
                    end
                end
                ACCESS: begin
                    // ack is checked first so it wins over a simultaneous timeout
                    if (ack_hit) begin
                        state   <= DONE;
                        PrReady <= 1'b1;
                        DevSel  <= '0;
                        DevWe   <= 1'b0;
                        if (!lat_we)
                            PrRD <= rd_sel;
                    end else if (cnt == 8'(TIMEOUT-1)) begin
                        state    <= DONE;
                        PrReady  <= 1'b1;
                        PrErr    <= 1'b1;
                        PrRD     <= '1;
                        err_addr <= lat_addr;
                        DevSel   <= '0;
                        DevWe    <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRIDGE_INT_EDGE_EN
    logic [NDEV-1:0] devint_q;
    logic [NDEV-1:0] pend_clr;

    always_comb begin
        pend_clr = '0;
        if (state == IDLE && PrReq && reg_hit && PrWe && PrBE[0]
            && woff == W_PEND)
            pend_clr = PrWD[NDEV-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            devint_q <= '0;
            int_pend <= '0;
        end else begin
            devint_q <= DevInt;
            int_pend <= (int_pend & ~pend_clr) | (DevInt & ~devint_q);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst)
            int_pend <= '0;
        else
            int_pend <= DevInt;
    end
`endif

endmodule
